// File: rtl/demod_scan_ctrl_pkg.sv
// ============================================================================
// demod_scan_pkg : shared state encoding and default widths for the scanner
// Rev 1.0
// ============================================================================
`default_nettype none

package demod_scan_pkg;

  localparam int DEF_MAG_WIDTH = 12;
  localparam int DEF_AVG_LOG2  = 6;
  localparam int ACC_WIDTH     = DEF_MAG_WIDTH + DEF_AVG_LOG2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    TUNE    = 3'd1,
    SETTLE  = 3'd2,
    MEASURE = 3'd3,
    COMPARE = 3'd4,
    LOCK    = 3'd5
  } scan_state_t;

endpackage

`default_nettype wire

// File: rtl/demod_scan_ctrl_avg_meter.sv
// ============================================================================
// scan_avg_meter : strobe-qualified settle counter and magnitude accumulator
// Rev 1.0
// ============================================================================
`default_nettype none

module scan_avg_meter
  import demod_scan_pkg::*;
#(
  parameter int MAG_WIDTH      = DEF_MAG_WIDTH,
  parameter int AVG_LOG2       = DEF_AVG_LOG2,
  parameter int SETTLE_SAMPLES = 64,
  parameter int ACC_W          = ACC_WIDTH
) (
  input  logic                 clk_in,
  input  logic                 RST,
  input  logic                 clear,
  input  logic                 settle_en,
  input  logic                 meas_en,
  input  logic                 am_valid,
  input  logic [MAG_WIDTH-1:0] am_in,
  output logic                 settle_done,
  output logic                 meas_done,
  output logic [MAG_WIDTH-1:0] level
);

  localparam int c_settle_w    = (SETTLE_SAMPLES > 1) ? $clog2(SETTLE_SAMPLES) : 1;
  localparam int c_settle_last = (SETTLE_SAMPLES > 0) ? SETTLE_SAMPLES - 1 : 0;
  localparam int c_meas_w      = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int c_meas_last   = (1 << AVG_LOG2) - 1;

  logic [c_settle_w-1:0] r_settle_cnt;
  logic [c_meas_w-1:0]   r_meas_cnt;
  logic [ACC_W-1:0]      r_acc;

  assign settle_done = settle_en && am_valid && (r_settle_cnt == c_settle_w'(c_settle_last));
  assign meas_done   = meas_en && am_valid && (r_meas_cnt == c_meas_w'(c_meas_last));
  // Accumulator is wide enough that the top bits are exactly the truncated mean.
  assign level       = r_acc[AVG_LOG2 +: MAG_WIDTH];

  always_ff @(posedge clk_in) begin
    if (RST || clear) begin
      r_settle_cnt <= '0;
      r_meas_cnt   <= '0;
      r_acc        <= '0;
    end else begin
      if (settle_en && am_valid) begin
        r_settle_cnt <= r_settle_cnt + c_settle_w'(1);
      end
      if (meas_en && am_valid) begin
        r_meas_cnt <= r_meas_cnt + c_meas_w'(1);
        r_acc      <= r_acc + ACC_W'(am_in);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/demod_scan_ctrl.sv
// ============================================================================
// demod_scan_ctrl : steps the NCO across a channel list, averages AM level per
//                   channel and retunes/locks onto the strongest one
// Rev 1.0
// ============================================================================
`default_nettype none

module demod_scan_ctrl
  import demod_scan_pkg::*;
#(
  parameter int PHASE_WIDTH    = 32,
  parameter int MAG_WIDTH      = 12,
  parameter int CH_WIDTH       = 10,
  parameter int SETTLE_SAMPLES = 64,
  parameter int AVG_LOG2       = 6
) (
  input  logic                   clk_in,
  input  logic                   RST,
  input  logic                   start,
  input  logic                   abort,
  input  logic [PHASE_WIDTH-1:0] f_start,
  input  logic [PHASE_WIDTH-1:0] f_step,
  input  logic [CH_WIDTH-1:0]    f_count,
  input  logic                   am_valid,
  input  logic [MAG_WIDTH-1:0]   am_in,
  output logic [PHASE_WIDTH-1:0] Fre_word,
  output logic                   busy,
  output logic                   done,
  output logic                   locked,
  output logic [CH_WIDTH-1:0]    best_index,
  output logic [MAG_WIDTH-1:0]   best_level
);

  scan_state_t            r_state, w_state_nxt;
  logic [PHASE_WIDTH-1:0] r_freq, w_freq_nxt;
  logic [PHASE_WIDTH-1:0] r_step, w_step_nxt;
  logic [CH_WIDTH-1:0]    r_count, w_count_nxt;
  logic [CH_WIDTH-1:0]    r_idx, w_idx_nxt;
  logic [PHASE_WIDTH-1:0] r_fre_word, w_fre_nxt;
  logic [PHASE_WIDTH-1:0] r_best_freq, w_best_freq_nxt;
  logic [CH_WIDTH-1:0]    r_best_index, w_best_index_nxt;
  logic [MAG_WIDTH-1:0]   r_best_level, w_best_level_nxt;
  logic                   r_busy, w_busy_nxt;
  logic                   r_done, w_done_nxt;
  logic                   r_locked, w_locked_nxt;

  logic                   w_meter_clear;
  logic                   w_settle_done;
  logic                   w_meas_done;
  logic [MAG_WIDTH-1:0]   w_level;

  scan_avg_meter #(
    .MAG_WIDTH      (MAG_WIDTH),
    .AVG_LOG2       (AVG_LOG2),
    .SETTLE_SAMPLES (SETTLE_SAMPLES),
    .ACC_W          (MAG_WIDTH + AVG_LOG2)
  ) u_meter (
    .clk_in      (clk_in),
    .RST         (RST),
    .clear       (w_meter_clear),
    .settle_en   (r_state == SETTLE),
    .meas_en     (r_state == MEASURE),
    .am_valid    (am_valid),
    .am_in       (am_in),
    .settle_done (w_settle_done),
    .meas_done   (w_meas_done),
    .level       (w_level)
  );

  always_comb begin
    w_state_nxt      = r_state;
    w_freq_nxt       = r_freq;
    w_step_nxt       = r_step;
    w_count_nxt      = r_count;
    w_idx_nxt        = r_idx;
    w_fre_nxt        = r_fre_word;
    w_best_freq_nxt  = r_best_freq;
    w_best_index_nxt = r_best_index;
    w_best_level_nxt = r_best_level;
    w_busy_nxt       = r_busy;
    w_done_nxt       = 1'b0;
    w_locked_nxt     = r_locked;
    w_meter_clear    = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          if (f_count == '0) begin
            w_done_nxt = 1'b1;
          end else begin
            w_freq_nxt   = f_start;
            w_step_nxt   = f_step;
            w_count_nxt  = f_count;
            w_idx_nxt    = '0;
            w_locked_nxt = 1'b0;
            w_busy_nxt   = 1'b1;
            w_state_nxt  = TUNE;
          end
        end
      end
      TUNE: begin
        w_fre_nxt     = r_freq;
        w_meter_clear = 1'b1;
        w_state_nxt   = (SETTLE_SAMPLES == 0) ? MEASURE : SETTLE;
      end
      SETTLE: begin
        if (w_settle_done) w_state_nxt = MEASURE;
      end
      MEASURE: begin
        if (w_meas_done) w_state_nxt = COMPARE;
      end
      COMPARE: begin
        // Strict greater-than so a tie keeps the earlier channel.
        if ((r_idx == '0) || (w_level > r_best_level)) begin
          w_best_level_nxt = w_level;
          w_best_index_nxt = r_idx;
          w_best_freq_nxt  = r_freq;
        end
        if (r_idx == r_count - CH_WIDTH'(1)) begin
          w_state_nxt = LOCK;
        end else begin
          w_idx_nxt   = r_idx + CH_WIDTH'(1);
          w_freq_nxt  = r_freq + r_step;
          w_state_nxt = TUNE;
        end
      end
      LOCK: begin
        w_fre_nxt    = r_best_freq;
        w_locked_nxt = 1'b1;
        w_done_nxt   = 1'b1;
        w_busy_nxt   = 1'b0;
        w_state_nxt  = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Abort freezes the tuned word and partial results and drops everything else.
    if (abort && (r_state != IDLE)) begin
      w_state_nxt      = IDLE;
      w_busy_nxt       = 1'b0;
      w_locked_nxt     = 1'b0;
      w_done_nxt       = 1'b0;
      w_fre_nxt        = r_fre_word;
      w_best_freq_nxt  = r_best_freq;
      w_best_index_nxt = r_best_index;
      w_best_level_nxt = r_best_level;
    end
  end

  always_ff @(posedge clk_in) begin
    if (RST) begin
      r_state      <= IDLE;
      r_freq       <= '0;
      r_step       <= '0;
      r_count      <= '0;
      r_idx        <= '0;
      r_fre_word   <= '0;
      r_best_freq  <= '0;
      r_best_index <= '0;
      r_best_level <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_locked     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_freq       <= w_freq_nxt;
      r_step       <= w_step_nxt;
      r_count      <= w_count_nxt;
      r_idx        <= w_idx_nxt;
      r_fre_word   <= w_fre_nxt;
      r_best_freq  <= w_best_freq_nxt;
      r_best_index <= w_best_index_nxt;
      r_best_level <= w_best_level_nxt;
      r_busy       <= w_busy_nxt;
      r_done       <= w_done_nxt;
      r_locked     <= w_locked_nxt;
    end
  end

  assign Fre_word   = r_fre_word;
  assign busy       = r_busy;
  assign done       = r_done;
  assign locked     = r_locked;
  assign best_index = r_best_index;
  assign best_level = r_best_level;

endmodule

`default_nettype wire

// File: tb/tb_demod_scan_ctrl.sv
// ============================================================================
// tb_demod_scan_ctrl : scoreboard bench for the channel-scan controller
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_demod_scan_ctrl;

  localparam int PW = 32;
  localparam int MW = 12;
  localparam int CW = 10;

  logic          clk_in = 1'b0;
  logic          RST, start, abort, am_valid;
  logic [PW-1:0] f_start, f_step;
  logic [CW-1:0] f_count;
  logic [MW-1:0] am_in;
  logic [PW-1:0] Fre_word;
  logic          busy, done, locked;
  logic [CW-1:0] best_index;
  logic [MW-1:0] best_level;

  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;
  bit            mon_en = 1'b0;
  logic [PW-1:0] q_fw[$];

  // Per-channel AM level model, keyed by tuned frequency word.
  logic [PW-1:0] tbl_f[4];
  int            tbl_l[4];
  logic [PW-1:0] bump_f;

  always #5 clk_in = ~clk_in;

  demod_scan_ctrl #(
    .PHASE_WIDTH    (PW),
    .MAG_WIDTH      (MW),
    .CH_WIDTH       (CW),
    .SETTLE_SAMPLES (4),
    .AVG_LOG2       (2)
  ) dut (
    .clk_in     (clk_in),
    .RST        (RST),
    .start      (start),
    .abort      (abort),
    .f_start    (f_start),
    .f_step     (f_step),
    .f_count    (f_count),
    .am_valid   (am_valid),
    .am_in      (am_in),
    .Fre_word   (Fre_word),
    .busy       (busy),
    .done       (done),
    .locked     (locked),
    .best_index (best_index),
    .best_level (best_level)
  );

  // Settle-window strobes carry a huge value so any that leak into the average show up.
  function automatic logic [MW-1:0] am_model(input logic [PW-1:0] f, input int k);
    int v;
    v = 0;
    if (k < 4) return MW'(4000);
    for (int i = 0; i < 4; i++) if (tbl_f[i] === f) v = tbl_l[i];
    if ((f === bump_f) && (k == 7)) v = v + 1;
    return MW'(v);
  endfunction

  initial begin : g_am_source
    logic [PW-1:0] prev;
    int            k;
    int            ph;
    am_valid = 1'b0;
    am_in    = '0;
    prev     = '0;
    k        = 0;
    ph       = 0;
    forever begin
      @(negedge clk_in);
      if (Fre_word !== prev) begin
        prev = Fre_word;
        k    = 0;
      end
      ph++;
      if (ph % 4 == 0) begin
        am_valid = 1'b1;
        am_in    = am_model(prev, k);
        k++;
      end else begin
        am_valid = 1'b0;
      end
    end
  end

  initial begin : g_monitor
    logic [PW-1:0] last;
    logic [PW-1:0] exp_fw;
    wait (mon_en);
    last = Fre_word;
    forever begin
      @(negedge clk_in);
      if (done === 1'b1) done_cnt++;
      if (Fre_word !== last) begin
        checks++;
        if (q_fw.size() == 0) begin
          errors++;
          $display("FAIL fre_word_unexpected got %h expected no change", Fre_word);
        end else begin
          exp_fw = q_fw.pop_front();
          if (Fre_word !== exp_fw) begin
            errors++;
            $display("FAIL fre_word_seq got %h expected %h", Fre_word, exp_fw);
          end
        end
        last = Fre_word;
      end
    end
  end

  task automatic do_start(input logic [PW-1:0] fs, input logic [PW-1:0] st, input logic [CW-1:0] cnt);
    f_start = fs;
    f_step  = st;
    f_count = cnt;
    start   = 1'b1;
    @(negedge clk_in);
    start   = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (done === 1'b1) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk_in);
    end
  endtask

  task automatic wait_fw(input logic [PW-1:0] v, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (Fre_word === v) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk_in);
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; start = 1'b0; abort = 1'b0;
    f_start = '0; f_step = '0; f_count = '0;
    repeat (3) @(negedge clk_in);
    RST = 1'b0;
    @(negedge clk_in);
    checks++; if (Fre_word !== 32'h0)  begin errors++; $display("FAIL reset_fre_word got %h expected 0", Fre_word); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done got %b expected 0", done); end
    checks++; if (locked !== 1'b0)     begin errors++; $display("FAIL reset_locked got %b expected 0", locked); end
    checks++; if (best_index !== '0)   begin errors++; $display("FAIL reset_best_index got %0d expected 0", best_index); end
    checks++; if (best_level !== '0)   begin errors++; $display("FAIL reset_best_level got %0d expected 0", best_level); end
    mon_en = 1'b1;
  endtask

  task automatic test_basic_scan();
    bit ok;
    int d0;
    tbl_f = '{32'h1000_0000, 32'h1100_0000, 32'h1200_0000, 32'hFFFF_FFFF};
    tbl_l = '{100, 300, 200, 0};
    bump_f = 32'h0BAD_0000;
    q_fw.push_back(32'h1000_0000);
    q_fw.push_back(32'h1100_0000);
    q_fw.push_back(32'h1200_0000);
    q_fw.push_back(32'h1100_0000);
    d0 = done_cnt;
    do_start(32'h1000_0000, 32'h0100_0000, CW'(3));
    checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL basic_busy_rise got %b expected 1", busy); end
    checks++; if (Fre_word !== 32'h0) begin errors++; $display("FAIL basic_fre_early got %h expected 0", Fre_word); end
    @(negedge clk_in);
    checks++; if (Fre_word !== 32'h1000_0000) begin errors++; $display("FAIL basic_fre_ch0 got %h expected 10000000", Fre_word); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got no done expected done"); end
    checks++; if (best_index !== CW'(1))   begin errors++; $display("FAIL basic_best_index got %0d expected 1", best_index); end
    checks++; if (best_level !== MW'(300)) begin errors++; $display("FAIL basic_best_level got %0d expected 300", best_level); end
    checks++; if (locked !== 1'b1)         begin errors++; $display("FAIL basic_locked got %b expected 1", locked); end
    checks++; if (busy !== 1'b0)           begin errors++; $display("FAIL basic_busy_end got %b expected 0", busy); end
    checks++; if (Fre_word !== 32'h1100_0000) begin errors++; $display("FAIL basic_lock_word got %h expected 11000000", Fre_word); end
    @(negedge clk_in);
    checks++; if (done !== 1'b0)         begin errors++; $display("FAIL basic_done_width got %b expected 0", done); end
    checks++; if (done_cnt - d0 != 1)    begin errors++; $display("FAIL basic_done_count got %0d expected 1", done_cnt - d0); end
    checks++; if (q_fw.size() != 0)      begin errors++; $display("FAIL basic_queue_left got %0d expected 0", q_fw.size()); end
  endtask

  task automatic test_tie();
    bit ok;
    tbl_f = '{32'h2000_0000, 32'h2100_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl_l = '{10, 10, 0, 0};
    bump_f = 32'h2000_0000;
    q_fw.push_back(32'h2000_0000);
    q_fw.push_back(32'h2100_0000);
    q_fw.push_back(32'h2000_0000);
    do_start(32'h2000_0000, 32'h0100_0000, CW'(2));
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL tie_locked_clear got %b expected 0", locked); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL tie_timeout got no done expected done"); end
    checks++; if (best_index !== CW'(0))  begin errors++; $display("FAIL tie_best_index got %0d expected 0", best_index); end
    checks++; if (best_level !== MW'(10)) begin errors++; $display("FAIL tie_best_level got %0d expected 10", best_level); end
    checks++; if (Fre_word !== 32'h2000_0000) begin errors++; $display("FAIL tie_lock_word got %h expected 20000000", Fre_word); end
    @(negedge clk_in);
    checks++; if (q_fw.size() != 0) begin errors++; $display("FAIL tie_queue_left got %0d expected 0", q_fw.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    tbl_f = '{32'hFFFF_FF00, 32'h0000_0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl_l = '{50, 900, 0, 0};
    bump_f = 32'h0BAD_0000;
    q_fw.push_back(32'hFFFF_FF00);
    q_fw.push_back(32'h0000_0100);
    do_start(32'hFFFF_FF00, 32'h0000_0200, CW'(2));
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout got no done expected done"); end
    checks++; if (best_index !== CW'(1))   begin errors++; $display("FAIL wrap_best_index got %0d expected 1", best_index); end
    checks++; if (best_level !== MW'(900)) begin errors++; $display("FAIL wrap_best_level got %0d expected 900", best_level); end
    checks++; if (Fre_word !== 32'h0000_0100) begin errors++; $display("FAIL wrap_lock_word got %h expected 00000100", Fre_word); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL wrap_locked got %b expected 1", locked); end
    @(negedge clk_in);
    checks++; if (q_fw.size() != 0) begin errors++; $display("FAIL wrap_queue_left got %0d expected 0", q_fw.size()); end
  endtask

  task automatic test_zero_count();
    int d0;
    d0 = done_cnt;
    do_start(32'h5555_0000, 32'h0000_0001, CW'(0));
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zero_done got %b expected 1", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy got %b expected 0", busy); end
    @(negedge clk_in);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_done_width got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL zero_busy_after got %b expected 0", busy); end
    checks++; if (Fre_word !== 32'h0000_0100) begin errors++; $display("FAIL zero_fre_word got %h expected 00000100", Fre_word); end
    checks++; if (locked !== 1'b1) begin errors++; $display("FAIL zero_locked got %b expected 1", locked); end
    checks++; if (best_index !== CW'(1)) begin errors++; $display("FAIL zero_best_index got %0d expected 1", best_index); end
    checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL zero_done_count got %0d expected 1", done_cnt - d0); end
  endtask

  task automatic test_abort();
    bit ok;
    int d0;
    tbl_f = '{32'h3000_0000, 32'h3010_0000, 32'h3020_0000, 32'hFFFF_FFFF};
    tbl_l = '{77, 500, 9, 0};
    bump_f = 32'h0BAD_0000;
    q_fw.push_back(32'h3000_0000);
    q_fw.push_back(32'h3010_0000);
    do_start(32'h3000_0000, 32'h0010_0000, CW'(3));
    wait_fw(32'h3010_0000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_reach_ch1 got %h expected 30100000", Fre_word); end
    d0 = done_cnt;
    repeat (22) @(negedge clk_in);
    f_start = 32'h7000_0000; f_count = CW'(5);
    start = 1'b1; abort = 1'b1;
    @(negedge clk_in);
    start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL abort_busy got %b expected 0", busy); end
    checks++; if (locked !== 1'b0) begin errors++; $display("FAIL abort_locked got %b expected 0", locked); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL abort_done got %b expected 0", done); end
    checks++; if (Fre_word !== 32'h3010_0000) begin errors++; $display("FAIL abort_fre_hold got %h expected 30100000", Fre_word); end
    checks++; if (best_index !== CW'(0))  begin errors++; $display("FAIL abort_best_index got %0d expected 0", best_index); end
    checks++; if (best_level !== MW'(77)) begin errors++; $display("FAIL abort_best_level got %0d expected 77", best_level); end
    repeat (20) @(negedge clk_in);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_stays_idle got %b expected 0", busy); end
    checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done got %0d expected %0d", done_cnt, d0); end
    checks++; if (q_fw.size() != 0) begin errors++; $display("FAIL abort_queue_left got %0d expected 0", q_fw.size()); end
  endtask

  task automatic test_reset_mid_scan();
    bit ok;
    tbl_f = '{32'h4000_0000, 32'h4100_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    tbl_l = '{600, 250, 0, 0};
    bump_f = 32'h0BAD_0000;
    q_fw.push_back(32'h4000_0000);
    do_start(32'h4000_0000, 32'h0100_0000, CW'(2));
    wait_fw(32'h4000_0000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_reach_ch0 got %h expected 40000000", Fre_word); end
    repeat (3) @(negedge clk_in);
    q_fw.push_back(32'h0);
    RST = 1'b1;
    @(negedge clk_in);
    RST = 1'b0;
    checks++; if (Fre_word !== 32'h0) begin errors++; $display("FAIL rstmid_fre_word got %h expected 0", Fre_word); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL rstmid_busy got %b expected 0", busy); end
    checks++; if (locked !== 1'b0)    begin errors++; $display("FAIL rstmid_locked got %b expected 0", locked); end
    checks++; if (best_index !== '0)  begin errors++; $display("FAIL rstmid_best_index got %0d expected 0", best_index); end
    checks++; if (best_level !== '0)  begin errors++; $display("FAIL rstmid_best_level got %0d expected 0", best_level); end
    q_fw.push_back(32'h4000_0000);
    q_fw.push_back(32'h4100_0000);
    q_fw.push_back(32'h4000_0000);
    do_start(32'h4000_0000, 32'h0100_0000, CW'(2));
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout got no done expected done"); end
    checks++; if (best_index !== CW'(0))   begin errors++; $display("FAIL rstmid_rescan_index got %0d expected 0", best_index); end
    checks++; if (best_level !== MW'(600)) begin errors++; $display("FAIL rstmid_rescan_level got %0d expected 600", best_level); end
    checks++; if (locked !== 1'b1)         begin errors++; $display("FAIL rstmid_rescan_locked got %b expected 1", locked); end
    @(negedge clk_in);
    checks++; if (q_fw.size() != 0) begin errors++; $display("FAIL rstmid_queue_left got %0d expected 0", q_fw.size()); end
  endtask

  initial begin : g_watchdog
    #2_000_000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin : g_main
    test_reset();
    test_basic_scan();
    test_tie();
    test_wrap();
    test_zero_count();
    test_abort();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/demod_scan_ctrl.md
Name: demod_scan_ctrl

Overview:
- Channel-scan and tune controller for the IQ demodulator chain.
- Steps the NCO frequency word across a programmed channel list and waits for the mixer/CIC chain to settle at each step.
- At each channel, averages the AM (CORDIC magnitude) output and keeps the strongest channel.
- When the scan completes, retunes to the strongest channel and asserts lock. The FM, PM and AM outputs are then valid for the selected carrier.

Parameters:
- PHASE_WIDTH, 32: width of the frequency word, start and step.
- MAG_WIDTH, 12: width of the AM magnitude input. Matches the demodulator OUTPUT_WIDTH.
- CH_WIDTH, 10: width of the channel count and channel index.
- SETTLE_SAMPLES, 64: number of am_valid strobes discarded after each retune.
- AVG_LOG2, 6: log2 of the number of am_valid strobes averaged per channel.

Ports:
- clk_in, in, 1: system clock. Same domain as the demodulator input clock.
- RST, in, 1: reset, synchronous, active-high.
- start, in, 1: single-cycle pulse that begins a scan. Ignored while busy=1.
- abort, in, 1: single-cycle pulse that stops a scan. Ignored while idle.
- f_start, in, PHASE_WIDTH: frequency word of channel 0. Sampled on start.
- f_step, in, PHASE_WIDTH: frequency-word increment per channel. Sampled on start.
- f_count, in, CH_WIDTH: number of channels to scan. Sampled on start.
- am_valid, in, 1: one-cycle strobe marking a new magnitude sample. Decimated-rate qualifier in the clk_in domain.
- am_in, in, MAG_WIDTH: unsigned AM magnitude.
- Fre_word, out, PHASE_WIDTH: frequency word driven to the demodulator.
- busy, out, 1: high from the cycle after an accepted start until return to IDLE.
- done, out, 1: one-cycle pulse at scan end (normal completion or f_count=0). Not asserted on abort.
- locked, out, 1: high while tuned to the winning channel.
- best_index, out, CH_WIDTH: index of the winning channel.
- best_level, out, MAG_WIDTH: averaged magnitude of the winning channel.

Behaviour:
- Reset values: Fre_word=0, busy=0, done=0, locked=0, best_index=0, best_level=0. State is IDLE, and all counters and the accumulator are cleared.
- State machine: IDLE -> TUNE -> SETTLE -> MEASURE -> COMPARE -> (TUNE | LOCK) -> IDLE.
- IDLE:
  - start=1 with f_count>0: latch start/step/count, clear locked, go to TUNE.
  - start=1 with f_count=0: pulse done the next cycle. Fre_word, locked and best_* are unchanged.
- TUNE (1 cycle): Fre_word <= f_start + idx*f_step, computed as a running sum.
  - Addition is modulo 2^PHASE_WIDTH; wrap-around is legal.
  - Fre_word for channel 0 is visible 2 cycles after the start pulse.
  - Settle and sample counters are cleared.
- SETTLE: count am_valid strobes. Go to MEASURE on the cycle the SETTLE_SAMPLES-th strobe is seen.
  - SETTLE_SAMPLES=0 skips this state.
- MEASURE: on each am_valid, acc += am_in.
  - Accumulator width is MAG_WIDTH+AVG_LOG2, so no overflow is possible.
  - After 2^AVG_LOG2 strobes, go to COMPARE.
- COMPARE (1 cycle): level = acc >> AVG_LOG2 (truncating).
  - Channel 0: always take level as best.
  - Other channels: take level as best only if level > best_level. A tie keeps the lower index.
  - If idx == count-1, go to LOCK. Otherwise idx++, running frequency += step, go to TUNE.
- LOCK (1 cycle): Fre_word <= winning frequency word (stored alongside best_index), locked <= 1, done pulse, busy <= 0 next cycle, go to IDLE.
- locked stays high until the next accepted start, an abort, or RST.
- Any am_valid strobes in TUNE, COMPARE, LOCK or IDLE are ignored.
- abort during a scan: go to IDLE next cycle with busy=0, locked=0, done=0.
  - Fre_word holds its current value.
  - best_* hold their partial-scan values.
- abort and start in the same cycle: abort wins. start is ignored because busy=1.
- RST mid-scan: all outputs return to reset values on the next clock edge.

Decomposition:
- Package demod_scan_pkg: the state enum (IDLE, TUNE, SETTLE, MEASURE, COMPARE, LOCK) and a localparam ACC_WIDTH = MAG_WIDTH+AVG_LOG2.
- One sub-module, scan_avg_meter: strobe-qualified settle counter plus accumulator.
  - Inputs: clear, settle/measure enable, am_valid, am_in.
  - Outputs: level and meas_done.
  - This keeps the FSM purely sequencing.

Test Plan (bench parameters: SETTLE_SAMPLES=4, AVG_LOG2=2, am_valid every 4th cycle):
- Basic scan: f_start=0x1000_0000, f_step=0x0100_0000, f_count=3, am_in=100/300/200 per channel -> Fre_word steps through 0x1000_0000, 0x1100_0000, 0x1200_0000 and ends at 0x1100_0000. best_index=1, best_level=300, one done pulse, locked=1.
- Tie plus truncation: am_in on channel 0 = 10,10,10,11 (avg 10); channel 1 = 10 constant -> best_index=0, best_level=10.
- Wrap-around: f_start=0xFFFF_FF00, f_step=0x200, f_count=2 -> channel 1 Fre_word=0x0000_0100. Strongest on channel 1 -> locked on 0x0000_0100.
- f_count=0: start -> done pulse 1 cycle later, busy stays 0, Fre_word and locked unchanged.
- Abort during MEASURE of channel 1, with start and abort in the same cycle -> IDLE next cycle, busy=0, locked=0, no done, Fre_word holds channel 1's word.
- RST asserted in SETTLE -> next edge: Fre_word=0, busy=0, locked=0, best_*=0. A fresh start after reset runs a full scan.
